// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave
//   AXI4-lite responder in front of a word-addressed synchronous RAM.
//   Independent read and write paths, one outstanding transaction each,
//   registered responses. RAM contents survive reset.
//
// Optional feature: define AXI_MEM_RANGE_CHECK_EN to answer addresses outside
//   [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) with SLVERR (no RAM write, RDATA=0).
//   Without it, addresses alias modulo the RAM size and always answer OKAY.
//
// Ports
//   CLK, RSTn                  clock (rising edge), async active-low reset
//   S_AXI_AW* / S_AXI_W*       write address / write data channels
//   S_AXI_B*                   write response channel
//   S_AXI_AR* / S_AXI_R*       read address / read data channels
//   S_AXI_AWPROT, S_AXI_ARPROT accepted and ignored
//
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY=1, waiting for an address
//   R_FETCH | address latched, RAM read into RDATA this edge
//   R_RESP  | RVALID=1, holding RDATA/RRESP until RREADY
module axi_lite_mem_slave #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_PROT_WIDTH   = 3,
  parameter int AXI_RESP_WIDTH   = 2,
  parameter int DEPTH_WORDS      = 4096,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter string INIT_FILE     = ""
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [AXI_PROT_WIDTH-1:0]   S_AXI_AWPROT,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_STROBE_WIDTH-1:0] S_AXI_WSTRB,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  output logic [AXI_RESP_WIDTH-1:0]   S_AXI_BRESP,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [AXI_PROT_WIDTH-1:0]   S_AXI_ARPROT,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [AXI_RESP_WIDTH-1:0]   S_AXI_RRESP
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

  logic [AXI_DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic                        r_aw_full;
  logic [AXI_ADDR_WIDTH-1:0]   r_aw_addr;
  logic                        r_w_full;
  logic [AXI_DATA_WIDTH-1:0]   r_w_data;
  logic [AXI_STROBE_WIDTH-1:0] r_w_strb;
  logic                        r_bvalid;
  logic [AXI_RESP_WIDTH-1:0]   r_bresp;

  r_state_t                    r_state;
  r_state_t                    w_r_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   r_ar_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [AXI_RESP_WIDTH-1:0]   r_rresp;

  logic                        w_awready;
  logic                        w_wready;
  logic                        w_commit;
  logic                        w_arready;
  logic                        w_rvalid;
  logic [AXI_ADDR_WIDTH-1:0]   w_aw_off;
  logic [AXI_ADDR_WIDTH-1:0]   w_ar_off;
  logic [IDX_W-1:0]            w_aw_idx;
  logic [IDX_W-1:0]            w_ar_idx;
  logic                        w_aw_ok;
  logic                        w_ar_ok;
  logic                        w_unused_ok;

  // Offsets wrap modulo 2^AXI_ADDR_WIDTH, so an address below BASE_ADDR
  // becomes a huge offset and fails the range compare naturally.
  assign w_aw_off = r_aw_addr - BASE_ADDR;
  assign w_ar_off = r_ar_addr - BASE_ADDR;
  assign w_aw_idx = w_aw_off[IDX_W+1:2];
  assign w_ar_idx = w_ar_off[IDX_W+1:2];

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam logic [AXI_ADDR_WIDTH:0] DEPTH_EXT = (AXI_ADDR_WIDTH+1)'(DEPTH_WORDS);
  localparam logic [AXI_ADDR_WIDTH:0] SPAN      = DEPTH_EXT << 2;
  assign w_aw_ok = ({1'b0, w_aw_off} < SPAN);
  assign w_ar_ok = ({1'b0, w_ar_off} < SPAN);
`else
  assign w_aw_ok = 1'b1;
  assign w_ar_ok = 1'b1;
`endif

  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_aw_off, w_ar_off};

  // ---------------- write path ----------------
  assign w_awready = !r_aw_full && !r_bvalid;
  assign w_wready  = !r_w_full && !r_bvalid;
  // Commit only once both holding registers were filled on earlier edges.
  assign w_commit  = r_aw_full && r_w_full;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (S_AXI_AWVALID && w_awready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && w_wready) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
      if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_commit && w_aw_ok) begin
      for (int i = 0; i < AXI_STROBE_WIDTH; i++) begin
        if (r_w_strb[i]) begin
          r_mem[w_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_r_state_nxt;
    end
  end

  always_comb begin
    w_r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (S_AXI_ARVALID) w_r_state_nxt = R_FETCH;
      R_FETCH: w_r_state_nxt = R_RESP;
      R_RESP:  if (S_AXI_RREADY) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_arready = (r_state == R_IDLE);
    w_rvalid  = (r_state == R_RESP);
  end

  // Nonblocking RAM read in R_FETCH sees the pre-commit word on a same-edge
  // collision, giving read-before-write.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ar_addr <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (r_state == R_IDLE && S_AXI_ARVALID) begin
        r_ar_addr <= S_AXI_ARADDR;
      end
      if (r_state == R_FETCH) begin
        r_rdata <= w_ar_ok ? r_mem[w_ar_idx] : '0;
        r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
module tb_axi_lite_mem_slave;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK(clk), .RSTn(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model [DEPTH];

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef AXI_MEM_RANGE_CHECK_EN
    longint off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < DEPTH * 4);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    return int'((off >> 2) % DEPTH);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return addr_ok(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return addr_ok(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (addr_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  int aw_e, w_e, ar_e;

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int skew, input int bst);
    bit aw_done, w_done;
    int t;
    logic [1:0] er;
    aw_done = 0; w_done = 0; t = 0;
    er = exp_resp(a);
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= skew);
      wvalid  = !w_done && (t >= -skew);
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_while_w_buffered", wready, 1'b0);
      if (aw_done && !w_done) chk("awready_while_aw_buffered", awready, 1'b0);
      if (awvalid && awready) begin aw_done = 1; aw_e = cyc + 1; end
      if (wvalid && wready) begin w_done = 1; w_e = cyc + 1; end
      @(posedge clk); #1;
      t++;
    end
    awvalid = 0; wvalid = 0;
    chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
    chk("bvalid_before_commit", bvalid, 1'b0);
    model_write(a, d, s);
    @(posedge clk); #1;
    chk("bvalid_latency", bvalid, 1'b1);
    chk("bresp", bresp, er);
    repeat (bst) begin
      @(posedge clk); #1;
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, er);
      chk("awready_stall", awready, 1'b0);
      chk("wready_stall", wready, 1'b0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("awready_back", awready, 1'b1);
    chk("wready_back", wready, 1'b1);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rst_cyc,
                          input logic [31:0] ed, input logic [1:0] er);
    bit done;
    int t;
    done = 0; t = 0;
    araddr = a; arvalid = 1;
    while (!done && t < 40) begin
      @(negedge clk);
      if (arready) begin done = 1; ar_e = cyc + 1; end
      @(posedge clk); #1;
      t++;
    end
    arvalid = 0;
    chk("ar_handshake", done, 1'b1);
    chk("rvalid_during_fetch", rvalid, 1'b0);
    chk("arready_during_fetch", arready, 1'b0);
    @(posedge clk); #1;
    chk("rvalid_latency", rvalid, 1'b1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    repeat (rst_cyc) begin
      @(posedge clk); #1;
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, ed);
      chk("rresp_hold", rresp, er);
      chk("arready_stall", arready, 1'b0);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_clear", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string where);
    chk({where, "_awready"}, awready, 1'b1);
    chk({where, "_wready"}, wready, 1'b1);
    chk({where, "_arready"}, arready, 1'b1);
    chk({where, "_bvalid"}, bvalid, 1'b0);
    chk({where, "_rvalid"}, rvalid, 1'b0);
    chk({where, "_bresp"}, bresp, 2'b00);
    chk({where, "_rresp"}, rresp, 2'b00);
    chk({where, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    // Give words 0..15 known contents.
    for (int i = 0; i < 16; i++)
      axi_write(BASE + 4 * i, $urandom, 4'hF, $urandom_range(0, 4) - 2, 0);

    // Full-word write with AW and W together, then readback.
    axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(BASE + 32'h10, 0, 32'hDEADBEEF, 2'b00);

    // W leads AW by three cycles, single byte lane.
    axi_write(BASE + 32'h10, 32'h0000AB00, 4'b0010, 3, 0);
    axi_read(BASE + 32'h10, 0, 32'hDEADABEF, 2'b00);

    // Backpressure on both response channels.
    axi_write(BASE + 32'h20, 32'h5A5A_1234, 4'hF, -2, 5);
    axi_read(BASE + 32'h20, 5, 32'h5A5A_1234, 2'b00);

    // Same-edge commit and fetch of one word: read sees the old value.
    axi_write(BASE + 32'h1C, 32'h22222222, 4'hF, 0, 0);
    fork
      axi_write(BASE + 32'h1C, 32'h11111111, 4'hF, 0, 0);
      axi_read(BASE + 32'h1C, 0, 32'h22222222, 2'b00);
    join
    chk("collision_same_edge", ar_e, aw_e);
    axi_read(BASE + 32'h1C, 0, 32'h11111111, 2'b00);

    // One past the end and one below the base.
    a = BASE + DEPTH * 4;
    axi_write(a, 32'hCAFEF00D, 4'hF, 0, 0);
    axi_read(a, 0, model_read(a), exp_resp(a));
    axi_read(BASE, 0, model[0], 2'b00);
    a = BASE - 4;
    axi_write(a, 32'h0BAD_0BAD, 4'hF, 1, 0);
    axi_read(a, 0, model_read(a), exp_resp(a));

    // Reset with a buffered W: it must be discarded.
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    chk("w_buffered_wready", wready, 1'b0);
    #2 rst_n = 0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    awaddr = BASE + 12; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_commit_of_discarded_w", bvalid, 1'b0);
    end
    wdata = 32'h3C3C_A5A5; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    model_write(BASE + 12, 32'h3C3C_A5A5, 4'hF);
    @(posedge clk); #1;
    chk("late_w_commit", bvalid, 1'b1);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    axi_read(BASE + 12, 0, 32'h3C3C_A5A5, 2'b00);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      a = BASE + 4 * $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) a = a + DEPTH * 4;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      end else begin
        axi_read(a, $urandom_range(0, 3), model_read(a), exp_resp(a));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
